// File: rtl/da_dct_odd_accumulator.sv
// Bit-serial distributed-arithmetic accumulator for one odd DCT row: walks the
// bit-planes of x0..x3 LSB first, addresses the coefficient ROM and shift-accumulates.
module da_dct_odd_accumulator #(
    parameter int                       DATA_W  = 16,
    parameter int                       ROM_W   = 17,
    parameter int                       ACC_W   = 36,
    parameter int                       ROM_LAT = 0,
    parameter logic signed [ACC_W-1:0]  OFFSET  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x0,
    input  logic [DATA_W-1:0] x1,
    input  logic [DATA_W-1:0] x2,
    input  logic [DATA_W-1:0] x3,
    output logic              rom_cs,
    output logic [2:0]        rom_addr,
    input  logic [ROM_W-1:0]  rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  y,
    output logic              busy
);

    localparam int             BW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0]  LAST_BIT = BW'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic                     ready_q;
    logic [DATA_W-1:0]        sr0_q, sr1_q, sr2_q, sr3_q;
    logic [BW-1:0]            bit_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  y_q;

    logic                     accept;
    logic                     issue;
    logic                     issue_inv;
    logic [2:0]               issue_addr;

    // Term stage: the plane whose ROM word is on rom_data this cycle.
    logic                     t_vld;
    logic                     t_inv;
    logic [BW-1:0]            t_bit;
    logic signed [ACC_W-1:0]  term_ext;
    logic signed [ACC_W-1:0]  term_sh;
    logic signed [ACC_W-1:0]  acc_nxt;
    logic                     last_term;

    assign in_ready  = (state_q == IDLE) && ready_q;
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign y         = y_q;

    // Symmetry fold: a set x0 bit selects the complemented address and a negated term.
    assign issue      = (state_q == RUN);
    assign issue_inv  = sr0_q[0];
    assign issue_addr = {sr1_q[0], sr2_q[0], sr3_q[0]};
    assign rom_cs     = issue;
    assign rom_addr   = issue ? (issue_inv ? ~issue_addr : issue_addr) : 3'b000;

    generate
        if (ROM_LAT == 0) begin : g_comb_rom
            assign t_vld = issue;
            assign t_inv = issue_inv;
            assign t_bit = bit_q;
        end else begin : g_reg_rom
            logic          p_vld_q;
            logic          p_inv_q;
            logic [BW-1:0] p_bit_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    p_vld_q <= 1'b0;
                    p_inv_q <= 1'b0;
                    p_bit_q <= '0;
                end else begin
                    p_vld_q <= issue;
                    p_inv_q <= issue_inv;
                    p_bit_q <= bit_q;
                end
            end

            assign t_vld = p_vld_q;
            assign t_inv = p_inv_q;
            assign t_bit = p_bit_q;
        end
    endgenerate

    // The sign plane carries weight -2^(DATA_W-1), so it is subtracted.
    assign term_ext  = ACC_W'($signed(rom_data));
    assign term_sh   = (t_inv ? -term_ext : term_ext) <<< t_bit;
    assign acc_nxt   = !t_vld ? acc_q
                     : (t_bit == LAST_BIT) ? acc_q - term_sh : acc_q + term_sh;
    assign last_term = t_vld && (t_bit == LAST_BIT);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (accept) state_d = RUN;
            RUN:   if (bit_q == LAST_BIT) state_d = (ROM_LAT == 0) ? DONE : DRAIN;
            DRAIN: state_d = DONE;
            DONE:  if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            sr0_q   <= '0;
            sr1_q   <= '0;
            sr2_q   <= '0;
            sr3_q   <= '0;
            bit_q   <= '0;
            acc_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= 1'b1;
            if (accept) begin
                sr0_q <= x0;
                sr1_q <= x1;
                sr2_q <= x2;
                sr3_q <= x3;
                bit_q <= '0;
                acc_q <= '0;
            end else begin
                acc_q <= acc_nxt;
                if (issue) begin
                    sr0_q <= sr0_q >> 1;
                    sr1_q <= sr1_q >> 1;
                    sr2_q <= sr2_q >> 1;
                    sr3_q <= sr3_q >> 1;
                    bit_q <= bit_q + 1'b1;
                end
            end
            if (last_term) y_q <= acc_nxt + OFFSET;
        end
    end

endmodule

// File: tb/tb_da_dct_odd_accumulator.sv
// Directed bench for da_dct_odd_accumulator: one instance with a combinational ROM
// and one with a registered ROM, checked against hand-computed results and a model.
module tb_da_dct_odd_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [15:0] x0 [2], x1 [2], x2 [2], x3 [2];
    logic        rom_cs    [2];
    logic [2:0]  rom_addr  [2];
    logic [16:0] rom_data  [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [35:0] y         [2];
    logic        busy      [2];

    int n_checks = 0;
    int n_bad    = 0;

    logic signed [16:0] tbl [8];
    initial begin
        tbl[0] = -17'sd4177;  tbl[1] = -17'sd9000;  tbl[2] = 17'sd2345;   tbl[3] = 17'sd7000;
        tbl[4] = -17'sd17800; tbl[5] = -17'sd1234;  tbl[6] = 17'sd5678;   tbl[7] = -17'sd11893;
    end

    always #5 clk = ~clk;

    da_dct_odd_accumulator #(.ROM_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .x0(x0[0]), .x1(x1[0]), .x2(x2[0]), .x3(x3[0]),
        .rom_cs(rom_cs[0]), .rom_addr(rom_addr[0]), .rom_data(rom_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .y(y[0]), .busy(busy[0])
    );

    da_dct_odd_accumulator #(.ROM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .x0(x0[1]), .x1(x1[1]), .x2(x2[1]), .x3(x3[1]),
        .rom_cs(rom_cs[1]), .rom_addr(rom_addr[1]), .rom_data(rom_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .y(y[1]), .busy(busy[1])
    );

    assign rom_data[0] = tbl[rom_addr[0]];
    always_ff @(posedge clk) rom_data[1] <= tbl[rom_addr[1]];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] plane_addr(input logic [15:0] a0, a1, a2, a3, input int b);
        logic [2:0] ad;
        ad = {a1[b], a2[b], a3[b]};
        return a0[b] ? ~ad : ad;
    endfunction

    function automatic logic [35:0] model(input logic [15:0] a0, a1, a2, a3);
        logic signed [35:0] acc, term;
        logic [2:0] ad;
        acc = '0;
        for (int b = 0; b < 16; b++) begin
            ad   = plane_addr(a0, a1, a2, a3, b);
            term = 36'(tbl[ad]);
            if (a0[b]) term = -term;
            if (b == 15) acc = acc - (term <<< b);
            else         acc = acc + (term <<< b);
        end
        return acc;
    endfunction

    // Drives one sample set into instance d and follows it through to the handshake.
    task automatic do_set(input int d, input logic [15:0] a0, a1, a2, a3,
                          input logic [35:0] exp_y, input int stall, input string tag,
                          output time t_acc);
        int          n;
        int          lat;
        bit          ok;
        logic [35:0] y_hold;
        t_acc = 0;
        n = 0;
        while (!in_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, " ready"}, 64'(in_ready[d]), 64'd1);
        if (!in_ready[d]) return;
        x0[d] = a0; x1[d] = a1; x2[d] = a2; x3[d] = a3;
        in_valid[d]  = 1'b1;
        out_ready[d] = (stall == 0);
        @(posedge clk);
        t_acc = $time;
        @(negedge clk);
        in_valid[d] = 1'b0;
        ok  = 1'b1;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (in_ready[d]) ok = 1'b0;
            if (out_valid[d]) begin
                lat = k;
                if (rom_cs[d]) ok = 1'b0;
                break;
            end
            if (k <= 16) begin
                if (!rom_cs[d] || rom_addr[d] != plane_addr(a0, a1, a2, a3, k - 1)) ok = 1'b0;
            end else if (rom_cs[d] || rom_addr[d] != 3'b000) begin
                ok = 1'b0;
            end
        end
        check({tag, " rom seq"}, 64'(ok), 64'd1);
        check({tag, " latency"}, 64'(lat), 64'(17 + d));
        check({tag, " y"}, 64'(y[d]), 64'(exp_y));
        if (lat == 0) return;
        y_hold = y[d];
        ok = 1'b1;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (!out_valid[d] || y[d] !== y_hold || in_ready[d]) ok = 1'b0;
        end
        if (stall > 0) check({tag, " hold"}, 64'(ok), 64'd1);
        out_ready[d] = 1'b1;
        @(negedge clk);
        check({tag, " release"}, 64'({out_valid[d], in_ready[d]}), 64'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        time         t_a, t_b;
        logic [15:0] r0, r1, r2, r3;
        bit          ok;

        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0; out_ready[d] = 1'b1;
            x0[d] = '0; x1[d] = '0; x2[d] = '0; x3[d] = '0;
        end

        // Reset state
        #12;
        for (int d = 0; d < 2; d++)
            check($sformatf("reset outputs d%0d", d),
                  64'({out_valid[d], rom_cs[d], rom_addr[d], busy[d], in_ready[d], y[d]}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("in_ready first cycle after release", 64'(in_ready[0]), 64'd0);
        @(negedge clk);
        check("in_ready after release", 64'(in_ready[0]), 64'd1);

        // Combinational ROM
        do_set(0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 36'h1051,     0, "l0 zeros", t_a);
        do_set(0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 36'(-11893), 0, "l0 x0 neg1", t_a);
        do_set(0, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 36'(-9446),  5, "l0 x1 one", t_a);
        for (int i = 0; i < 4; i++) begin
            r0 = 16'($urandom); r1 = 16'($urandom); r2 = 16'($urandom); r3 = 16'($urandom);
            do_set(0, r0, r1, r2, r3, model(r0, r1, r2, r3), 0, $sformatf("l0 rand%0d", i), t_b);
            if (i > 0) check("l0 period", 64'((t_b - t_a) / 10), 64'd18);
            t_a = t_b;
        end

        // Registered ROM
        do_set(1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 36'h1051,     0, "l1 zeros", t_a);
        do_set(1, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 36'(-11893), 0, "l1 x0 neg1", t_b);
        check("l1 period", 64'((t_b - t_a) / 10), 64'd19);
        do_set(1, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 36'(-9446),  3, "l1 x1 one", t_a);
        r0 = 16'h8001; r1 = 16'h7FFF; r2 = 16'h8000; r3 = 16'h5A5A;
        do_set(1, r0, r1, r2, r3, model(r0, r1, r2, r3), 0, "l1 corner", t_a);

        // Reset in the middle of a set: planes 0..7 issued, then reset at plane 7
        x0[0] = 16'h1234; x1[0] = 16'hABCD; x2[0] = 16'h0F0F; x3[0] = 16'h8888;
        in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (7) @(negedge clk);
        check("plane 7 addr before reset", 64'(rom_addr[0]),
              64'(plane_addr(16'h1234, 16'hABCD, 16'h0F0F, 16'h8888, 7)));
        #2 rst_n = 1'b0;
        #1 check("outputs in reset cycle",
                 64'({out_valid[0], rom_cs[0], rom_addr[0], busy[0], in_ready[0], y[0]}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("in_ready after mid reset", 64'(in_ready[0]), 64'd0);
        ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid[0] || busy[0]) ok = 1'b0;
        end
        check("no out_valid after mid reset", 64'(ok), 64'd1);
        r0 = 16'h1234; r1 = 16'hABCD; r2 = 16'h0F0F; r3 = 16'h8888;
        do_set(0, r0, r1, r2, r3, model(r0, r1, r2, r3), 0, "l0 after reset", t_a);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
